mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single unified memory port between the instruction-fetch stage and the data-access path driven by the decoder's `read_mmu` / `write_mmu` / `byte_select_mmu` outputs. It serialises requests into fixed-latency memory transactions and returns completion and read data to the granted requester. Data accesses have priority, with forced alternation under contention so fetch cannot starve. It sits between the pipeline front-end / MEM stage and the memory model.

## Interface
- `MEM_LATENCY`, 3: number of cycles `mem_req` is held per transaction; `mem_rdata` is valid in the last of them; legal values are 1 or more.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request, held until `if_grant` is seen.
- `if_addr` in 32: fetch address.
- `if_grant` out 1: one-cycle pulse, fetch request accepted.
- `if_valid` out 1: one-cycle pulse, fetch data on `if_rdata`.
- `if_rdata` out 32: fetched instruction word.
- `dc_req` in 1: data request (`read_mmu | write_mmu`), held until `dc_grant` is seen.
- `dc_write` in 1: 1 = store, 0 = load.
- `dc_byte` in 1: byte access (LDB/STB).
- `dc_addr` in 32: data address.
- `dc_wdata` in 32: store data.
- `dc_grant` out 1: one-cycle pulse, data request accepted.
- `dc_valid` out 1: one-cycle pulse, data access complete.
- `dc_rdata` out 32: load data; 0 for stores.
- `mem_req` out 1: memory transaction active.
- `mem_we` out 1: write enable.
- `mem_byte` out 1: byte select.
- `mem_addr` out 32: address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid in the last `mem_req` cycle.

## Operation
- States:
  - IDLE.
  - BUSY, with an owner bit (IF or DC).
  - Down-counter `cnt`, width clog2(MEM_LATENCY+1).
  - `last_dc` flag: set when the last grant went to DC.
- IDLE arbitration, evaluated on the clock edge:
  - Only `dc_req`: grant DC.
  - Only `if_req`: grant IF.
  - Both: grant IF if `last_dc`=1, else grant DC.
  - Neither: stay IDLE.
- On a grant:
  - Latch owner, address, `we` (= `dc_write` for DC, 0 for IF), `byte` (= `dc_byte` for DC, 0 for IF) and `wdata`.
  - Load `cnt` = MEM_LATENCY.
  - Enter BUSY.
  - Update `last_dc`.
- BUSY:
  - `mem_*` outputs drive the latched values with `mem_req`=1.
  - `cnt` decrements each cycle.
  - In the cycle with `cnt`=1, `mem_rdata` is registered into the owner's rdata.
  - At the end of that cycle the state returns to IDLE.
  - Request inputs are ignored throughout BUSY.
- Completion: the owner's `*_valid` pulses for exactly one cycle, in the first IDLE cycle after BUSY.
- Writes: `dc_rdata` is loaded with 0.
- Byte lane extraction and sign extension are outside this block; `mem_rdata` is passed unmodified.
- Outside BUSY: `mem_req`=0 and `mem_we`=0; `mem_addr`, `mem_wdata` and `mem_byte` hold their last values.

## Timing
- Reset (synchronous, applied at the edge):
  - State IDLE, `cnt`=0, `last_dc`=0.
  - All grant, valid and `mem_*` control outputs are 0.
  - `if_rdata`, `dc_rdata`, `mem_addr` and `mem_wdata` are 0.
- Request sampled in IDLE cycle T0. Then:
  - `*_grant`=1 in T1.
  - `mem_req`=1 in T1..T(MEM_LATENCY).
  - `*_valid`=1 with rdata in T(MEM_LATENCY+1).
- Latency from request to valid: MEM_LATENCY+1 cycles.
- Throughput: the IDLE cycle that carries `valid` also arbitrates, so back-to-back transactions have period MEM_LATENCY+1. Between transactions `mem_req` is low for exactly one cycle.
- Requester rule: hold `req` and the operands stable until `grant` is seen; deassert at the edge after grant. A req still high during BUSY is ignored. A req still high in the next IDLE cycle is treated as a new request.
- Simultaneous requests in IDLE: exactly one grant; the loser keeps its req and wins the next arbitration.
- MEM_LATENCY=1: `mem_req` lasts a single cycle, and `grant` and `mem_req` coincide in T1.
- Reset during BUSY:
  - The transaction is abandoned.
  - `mem_req` is 0 in the cycle after the reset edge.
  - No `valid` pulse is produced.
  - `last_dc` is cleared.
- `grant` and `valid` are never asserted in the same cycle for the same requester. `if_valid` and `dc_valid` are never both 1.

## Test plan
- Reset, then idle 5 cycles: all outputs 0; `mem_req` never rises.
- MEM_LATENCY=3, single fetch with `if_addr`=0x100 and memory returning 0x00A00093: `if_grant` in T1; `mem_req` in T1-T3 with `mem_addr`=0x100 and `mem_we`=0; `if_valid` in T4 with `if_rdata`=0x00A00093.
- STB with `dc_addr`=0x204, `dc_wdata`=0xAB, `dc_byte`=1: `mem_we`=1 and `mem_byte`=1 for 3 cycles; `dc_valid` in T4 with `dc_rdata`=0.
- `if_req` and `dc_req` held continuously for 4 transactions from reset: grant order DC, IF, DC, IF; grants spaced 4 cycles apart.
- LDW at 0x300, then `reset` asserted in T2: `mem_req`=0 in T3; no `dc_valid`; the next `if_req` is granted normally.
- MEM_LATENCY=1, back-to-back `dc_req`: `mem_req` pattern 1,0,1,0; `dc_valid` pulses in the 0 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory port bundle for the unified memory port arbiter
interface mem_port_arbiter_if;
    // instruction-fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_grant;
    logic        if_valid;
    logic [31:0] if_rdata;

    // data-access requester
    logic        dc_req;
    logic        dc_write;
    logic        dc_byte;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_grant;
    logic        dc_valid;
    logic [31:0] dc_rdata;

    // memory side
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_grant, if_valid, if_rdata,
        input  dc_req, dc_write, dc_byte, dc_addr, dc_wdata,
        output dc_grant, dc_valid, dc_rdata,
        output mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requester / memory-model view
    modport master (
        output if_req, if_addr,
        input  if_grant, if_valid, if_rdata,
        output dc_req, dc_write, dc_byte, dc_addr, dc_wdata,
        input  dc_grant, dc_valid, dc_rdata,
        input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-latency arbiter for the shared fetch/data memory port
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_last_dc;
    logic             w_last_dc_next;
    logic             w_grant_if;
    logic             w_grant_dc;
    logic             w_done;

    // latched transaction
    logic             r_owner_dc;
    logic [31:0]      r_addr;
    logic             r_we;
    logic             r_byte;
    logic [31:0]      r_wdata;

    // handshake pulses and returned data
    logic             r_if_grant;
    logic             r_dc_grant;
    logic             r_if_valid;
    logic             r_dc_valid;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_dc_rdata;

    // next-state: arbitrate in IDLE (DC first unless it won last time), count down in BUSY
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_last_dc_next = r_last_dc;
        w_grant_if     = 1'b0;
        w_grant_dc     = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.dc_req && !(bus.if_req && r_last_dc)) begin
                    w_grant_dc = 1'b1;
                end else if (bus.if_req) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_dc || w_grant_if) begin
                    w_next_state   = ST_BUSY;
                    w_cnt_next     = CNT_LOAD;
                    w_last_dc_next = w_grant_dc;
                end
            end
            ST_BUSY: begin
                w_cnt_next = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last_dc <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_last_dc <= w_last_dc_next;
        end
    end

    // capture the winner's operands; they keep driving mem_* after the transaction ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_dc <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_wdata    <= '0;
        end else if (w_grant_dc) begin
            r_owner_dc <= 1'b1;
            r_addr     <= bus.dc_addr;
            r_we       <= bus.dc_write;
            r_byte     <= bus.dc_byte;
            r_wdata    <= bus.dc_wdata;
        end else if (w_grant_if) begin
            r_owner_dc <= 1'b0;
            r_addr     <= bus.if_addr;
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_wdata    <= '0;
        end
    end

    // one-cycle grant and completion pulses to the owning requester
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_grant <= 1'b0;
            r_dc_grant <= 1'b0;
            r_if_valid <= 1'b0;
            r_dc_valid <= 1'b0;
        end else begin
            r_if_grant <= w_grant_if;
            r_dc_grant <= w_grant_dc;
            r_if_valid <= w_done && !r_owner_dc;
            r_dc_valid <= w_done && r_owner_dc;
        end
    end

    // register read data in the last memory cycle; stores return zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_dc_rdata <= '0;
        end else if (w_done) begin
            if (r_owner_dc) begin
                r_dc_rdata <= r_we ? 32'h0 : bus.mem_rdata;
            end else begin
                r_if_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_grant  = r_if_grant;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dc_grant  = r_dc_grant;
    assign bus.dc_valid  = r_dc_valid;
    assign bus.dc_rdata  = r_dc_rdata;
    assign bus.mem_req   = (r_state == ST_BUSY);
    assign bus.mem_we    = (r_state == ST_BUSY) && r_we;
    assign bus.mem_byte  = r_byte;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at latency 3 and 1
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic        is_dc;
        logic [31:0] data;
    } exp_t;

    exp_t sb3[$];
    exp_t sb1[$];

    mem_port_arbiter_if b3();
    mem_port_arbiter_if b1();

    mem_port_arbiter #(.MEM_LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
    mem_port_arbiter #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A00093;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign b3.mem_rdata = mem_fn(b3.mem_addr);
    assign b1.mem_rdata = mem_fn(b1.mem_addr);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // scoreboard for the latency-3 port
    always @(negedge clk) begin : mon3
        exp_t e;
        exp_t g;
        if (b3.if_valid || b3.dc_valid) begin
            total++;
            g = {b3.dc_valid, b3.dc_valid ? b3.dc_rdata : b3.if_rdata};
            if (b3.if_valid && b3.dc_valid) begin
                bad++;
                $display("FAIL l3_both_valid got if_valid=1 dc_valid=1 exp only one");
            end else if (sb3.size() == 0) begin
                bad++;
                $display("FAIL l3_unexpected_valid got is_dc=%0b data=%h exp none", g.is_dc, g.data);
            end else begin
                e = sb3.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL l3_sb got is_dc=%0b data=%h exp is_dc=%0b data=%h", g.is_dc, g.data, e.is_dc, e.data);
                end
            end
        end
    end

    // scoreboard for the latency-1 port
    always @(negedge clk) begin : mon1
        exp_t e;
        exp_t g;
        if (b1.if_valid || b1.dc_valid) begin
            total++;
            g = {b1.dc_valid, b1.dc_valid ? b1.dc_rdata : b1.if_rdata};
            if (b1.if_valid && b1.dc_valid) begin
                bad++;
                $display("FAIL l1_both_valid got if_valid=1 dc_valid=1 exp only one");
            end else if (sb1.size() == 0) begin
                bad++;
                $display("FAIL l1_unexpected_valid got is_dc=%0b data=%h exp none", g.is_dc, g.data);
            end else begin
                e = sb1.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL l1_sb got is_dc=%0b data=%h exp is_dc=%0b data=%h", g.is_dc, g.data, e.is_dc, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        logic [134:0] o3;
        logic [134:0] o1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            o3 = {b3.if_grant, b3.if_valid, b3.if_rdata, b3.dc_grant, b3.dc_valid, b3.dc_rdata,
                  b3.mem_req, b3.mem_we, b3.mem_byte, b3.mem_addr, b3.mem_wdata};
            o1 = {b1.if_grant, b1.if_valid, b1.if_rdata, b1.dc_grant, b1.dc_valid, b1.dc_rdata,
                  b1.mem_req, b1.mem_we, b1.mem_byte, b1.mem_addr, b1.mem_wdata};
            total++;
            if (o3 !== '0) begin
                bad++;
                $display("FAIL reset_outputs_l3 cycle=%0d got=%h exp=0", c, o3);
            end
            total++;
            if (o1 !== '0) begin
                bad++;
                $display("FAIL reset_outputs_l1 cycle=%0d got=%h exp=0", c, o1);
            end
            tick();
        end
    endtask

    task automatic test_fetch();
        b3.if_addr = 32'h100;
        b3.if_req  = 1'b1;
        sb3.push_back({1'b0, 32'h00A00093});
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++;
            if (b3.if_grant !== (c == 1)) begin
                bad++;
                $display("FAIL fetch_grant cycle=%0d got=%0b exp=%0b", c, b3.if_grant, c == 1);
            end
            total++;
            if (b3.mem_req !== (c <= 3)) begin
                bad++;
                $display("FAIL fetch_mem_req cycle=%0d got=%0b exp=%0b", c, b3.mem_req, c <= 3);
            end
            if (c <= 3) begin
                total++;
                if ({b3.mem_addr, b3.mem_we} !== {32'h100, 1'b0}) begin
                    bad++;
                    $display("FAIL fetch_mem_bus cycle=%0d got addr=%h we=%0b exp addr=100 we=0", c, b3.mem_addr, b3.mem_we);
                end
            end
            total++;
            if (b3.if_valid !== (c == 4)) begin
                bad++;
                $display("FAIL fetch_valid cycle=%0d got=%0b exp=%0b", c, b3.if_valid, c == 4);
            end
            if (c == 4) begin
                total++;
                if (b3.if_rdata !== 32'h00A00093) begin
                    bad++;
                    $display("FAIL fetch_rdata got=%h exp=00a00093", b3.if_rdata);
                end
            end
            if (c == 1) b3.if_req = 1'b0;
        end
    endtask

    task automatic test_alternate();
        int g_cyc[$];
        bit g_dc[$];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b3.if_addr  = 32'h400;
        b3.dc_addr  = 32'h500;
        b3.dc_write = 1'b0;
        b3.dc_byte  = 1'b0;
        b3.if_req   = 1'b1;
        b3.dc_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb3.push_back({1'b1, mem_fn(32'h500)});
            else            sb3.push_back({1'b0, mem_fn(32'h400)});
        end
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (b3.if_grant && b3.dc_grant) begin
                total++;
                bad++;
                $display("FAIL alt_double_grant cycle=%0d got both exp one", c);
            end
            if (b3.if_grant || b3.dc_grant) begin
                g_cyc.push_back(c);
                g_dc.push_back(b3.dc_grant);
            end
            total++;
            if (b3.mem_req !== ((c <= 15) && (c % 4 != 0))) begin
                bad++;
                $display("FAIL alt_mem_req cycle=%0d got=%0b exp=%0b", c, b3.mem_req, (c <= 15) && (c % 4 != 0));
            end
            if (c == 13) begin
                b3.if_req = 1'b0;
                b3.dc_req = 1'b0;
            end
        end
        total++;
        if (g_cyc.size() !== 4) begin
            bad++;
            $display("FAIL alt_grant_count got=%0d exp=4", g_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (g_dc[k] !== (k % 2 == 0) || g_cyc[k] !== 1 + 4 * k) begin
                    bad++;
                    $display("FAIL alt_grant_%0d got dc=%0b cycle=%0d exp dc=%0b cycle=%0d", k, g_dc[k], g_cyc[k], k % 2 == 0, 1 + 4 * k);
                end
            end
        end
    endtask

    task automatic test_store();
        b3.dc_addr  = 32'h204;
        b3.dc_wdata = 32'hAB;
        b3.dc_byte  = 1'b1;
        b3.dc_write = 1'b1;
        b3.dc_req   = 1'b1;
        sb3.push_back({1'b1, 32'h0});
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (b3.dc_grant !== (c == 1)) begin
                bad++;
                $display("FAIL store_grant cycle=%0d got=%0b exp=%0b", c, b3.dc_grant, c == 1);
            end
            if (c <= 3) begin
                total++;
                if ({b3.mem_req, b3.mem_we, b3.mem_byte, b3.mem_addr, b3.mem_wdata} !== {1'b1, 1'b1, 1'b1, 32'h204, 32'hAB}) begin
                    bad++;
                    $display("FAIL store_mem_bus cycle=%0d got req=%0b we=%0b byte=%0b addr=%h wdata=%h exp 1 1 1 204 ab",
                             c, b3.mem_req, b3.mem_we, b3.mem_byte, b3.mem_addr, b3.mem_wdata);
                end
            end else begin
                total++;
                if ({b3.dc_valid, b3.dc_rdata, b3.mem_req, b3.mem_we, b3.mem_byte, b3.mem_addr} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h204}) begin
                    bad++;
                    $display("FAIL store_done got valid=%0b rdata=%h req=%0b we=%0b byte=%0b addr=%h exp 1 0 0 0 1 204",
                             b3.dc_valid, b3.dc_rdata, b3.mem_req, b3.mem_we, b3.mem_byte, b3.mem_addr);
                end
            end
            if (c == 1) begin
                b3.dc_req   = 1'b0;
                b3.dc_write = 1'b0;
                b3.dc_byte  = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_reset_busy();
        b3.dc_addr  = 32'h300;
        b3.dc_write = 1'b0;
        b3.dc_req   = 1'b1;
        tick();
        total++;
        if (b3.dc_grant !== 1'b1) begin
            bad++;
            $display("FAIL rb_grant got=%0b exp=1", b3.dc_grant);
        end
        b3.dc_req = 1'b0;
        tick();
        total++;
        if (b3.mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rb_mem_req_t2 got=%0b exp=1", b3.mem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            total++;
            if ({b3.mem_req, b3.dc_valid} !== 2'b00) begin
                bad++;
                $display("FAIL rb_abandon cycle=%0d got req=%0b valid=%0b exp 0 0", c, b3.mem_req, b3.dc_valid);
            end
            tick();
        end
        b3.if_addr = 32'h100;
        b3.if_req  = 1'b1;
        sb3.push_back({1'b0, 32'h00A00093});
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                total++;
                if (b3.if_grant !== 1'b1) begin
                    bad++;
                    $display("FAIL rb_next_grant got=%0b exp=1", b3.if_grant);
                end
                b3.if_req = 1'b0;
            end
            if (c == 4) begin
                total++;
                if (b3.if_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rb_next_valid got=%0b exp=1", b3.if_valid);
                end
            end
        end
        tick();
    endtask

    task automatic test_latency1();
        b1.dc_addr  = 32'h600;
        b1.dc_write = 1'b0;
        b1.dc_byte  = 1'b0;
        b1.dc_req   = 1'b1;
        sb1.push_back({1'b1, mem_fn(32'h600)});
        sb1.push_back({1'b1, mem_fn(32'h604)});
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++;
            if ({b1.mem_req, b1.dc_grant, b1.dc_valid} !== {c % 2 == 1 && c < 5, c % 2 == 1 && c < 5, c % 2 == 0}) begin
                bad++;
                $display("FAIL l1_pattern cycle=%0d got req=%0b grant=%0b valid=%0b exp req=%0b grant=%0b valid=%0b",
                         c, b1.mem_req, b1.dc_grant, b1.dc_valid, c % 2 == 1 && c < 5, c % 2 == 1 && c < 5, c % 2 == 0);
            end
            if (c == 1 || c == 3) begin
                total++;
                if (b1.mem_addr !== (c == 1 ? 32'h600 : 32'h604)) begin
                    bad++;
                    $display("FAIL l1_addr cycle=%0d got=%h exp=%h", c, b1.mem_addr, c == 1 ? 32'h600 : 32'h604);
                end
            end
            if (c == 1) b1.dc_addr = 32'h604;
            if (c == 3) b1.dc_req  = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.dc_req = 1'b0; b3.dc_write = 1'b0;
        b3.dc_byte = 1'b0; b3.dc_addr = '0; b3.dc_wdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.dc_req = 1'b0; b1.dc_write = 1'b0;
        b1.dc_byte = 1'b0; b1.dc_addr = '0; b1.dc_wdata = '0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_alternate();
        test_store();
        test_reset_busy();
        test_latency1();
        repeat (3) tick();
        total++;
        if (sb3.size() + sb1.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain got pending=%0d exp=0", sb3.size() + sb1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
